// File: rtl/category_vote_accumulator.sv
// Accumulates per-category popcounts of streamed output bits and reports the
// category with the most votes (lowest index wins ties) plus a 7-seg pattern.
module category_vote_accumulator #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 800,
  parameter int CHUNK             = 40,
  localparam int SUM_W  = $clog2(BITS_PER_CATEGORY + 1),
  localparam int IDX_W  = (CATEGORIES > 2) ? $clog2(CATEGORIES) : 1,
  localparam int BEATS  = BITS_PER_CATEGORY / CHUNK,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [SUM_W-1:0] out_value,
  output logic [6:0]       out_display,
  input  logic [IDX_W-1:0] score_sel,
  output logic [SUM_W-1:0] score
);

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_RESULT = 1'b1;

  function automatic logic [SUM_W-1:0] popcount(input logic [CHUNK-1:0] b);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + SUM_W'(b[i]);
    return n;
  endfunction

  function automatic logic [6:0] seg7(input logic [IDX_W-1:0] idx);
    logic [6:0] s;
    case (int'(idx))
      0:       s = 7'h3F;
      1:       s = 7'h06;
      2:       s = 7'h5B;
      3:       s = 7'h4F;
      4:       s = 7'h66;
      5:       s = 7'h6D;
      6:       s = 7'h7C;
      7:       s = 7'h07;
      8:       s = 7'h7F;
      9:       s = 7'h67;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  cat_q, cat_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [SUM_W-1:0]  best_val_q, best_val_d;
  logic [SUM_W-1:0]  score_q [CATEGORIES];

  logic              beat_fire;
  logic              last_beat;
  logic              last_cat;
  logic [SUM_W-1:0]  cat_sum;
  logic              score_we;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_RESULT);
  assign beat_fire = in_valid && in_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_cat  = (cat_q == IDX_W'(CATEGORIES - 1));
  assign cat_sum   = acc_q + popcount(in_bits);
  assign score_we  = beat_fire && last_beat;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cat_d      = cat_q;
    acc_d      = acc_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (beat_fire) begin
      if (last_beat) begin
        beat_d = '0;
        acc_d  = '0;
        // Strict compare keeps the lower index on ties.
        if (cat_q == '0 || cat_sum > best_val_q) begin
          best_idx_d = cat_q;
          best_val_d = cat_sum;
        end
        if (last_cat) begin
          cat_d   = '0;
          state_d = ST_RESULT;
        end else begin
          cat_d = cat_q + IDX_W'(1);
        end
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        acc_d  = cat_sum;
      end
    end else if (state_q == ST_RESULT && out_ready) begin
      state_d = ST_ACCUM;
      beat_d  = '0;
      cat_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      beat_q     <= '0;
      cat_q      <= '0;
      acc_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cat_q      <= cat_d;
      acc_q      <= acc_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CATEGORIES; i++) score_q[i] <= '0;
    end else if (score_we) begin
      score_q[cat_q] <= cat_sum;
    end
  end

  assign out_index   = out_valid ? best_idx_q : '0;
  assign out_value   = out_valid ? best_val_q : '0;
  assign out_display = out_valid ? seg7(best_idx_q) : 7'h00;
  assign score       = (int'(score_sel) < CATEGORIES) ? score_q[score_sel] : '0;

endmodule

// File: tb/tb_category_vote_accumulator.sv
// Directed bench for category_vote_accumulator: default build plus a tiny
// 3-category build, with hand-derived expected scores and winners.
module tb_category_vote_accumulator;

  localparam int CAT   = 10;
  localparam int BPC   = 800;
  localparam int CH    = 40;
  localparam int BEATS = BPC / CH;
  localparam int SUM_W = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CH-1:0]    in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [SUM_W-1:0] out_value;
  logic [6:0]       out_display;
  logic [IDX_W-1:0] score_sel;
  logic [SUM_W-1:0] score;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [3:0] s_in_bits;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [1:0] s_out_index;
  logic [3:0] s_out_value;
  logic [6:0] s_out_display;
  logic [1:0] s_score_sel;
  logic [3:0] s_score;

  always #5 clk = ~clk;

  category_vote_accumulator #(.CATEGORIES(CAT), .BITS_PER_CATEGORY(BPC), .CHUNK(CH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_value(out_value), .out_display(out_display), .score_sel(score_sel), .score(score)
  );

  category_vote_accumulator #(.CATEGORIES(3), .BITS_PER_CATEGORY(8), .CHUNK(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bits(s_in_bits),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_index(s_out_index),
    .out_value(s_out_value), .out_display(s_out_display), .score_sel(s_score_sel),
    .score(s_score)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [CH-1:0] frame [CAT*BEATS];

  function automatic logic [6:0] seg_ref(input int idx);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
    return (idx < 10) ? t[idx] : 7'h00;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < CAT*BEATS; i++) frame[i] = '0;
  endtask

  // Place n ones into category c, filling beats from the first one.
  task automatic set_cat_ones(input int c, input int n);
    for (int b = 0; b < BEATS; b++) begin
      logic [CH-1:0] v;
      v = '0;
      for (int j = 0; j < CH; j++) if (b*CH + j < n) v[j] = 1'b1;
      frame[c*BEATS + b] = v;
    end
  endtask

  task automatic send_frame(input int gap_pct);
    for (int i = 0; i < CAT*BEATS; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_bits = CH'({$urandom, $urandom});
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_bits  = frame[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input bit check_scores);
    int sums [CAT];
    int bi;
    int bv;
    for (int c = 0; c < CAT; c++) begin
      sums[c] = 0;
      for (int b = 0; b < BEATS; b++) sums[c] += $countones(frame[c*BEATS + b]);
    end
    bi = 0;
    bv = sums[0];
    for (int c = 1; c < CAT; c++) if (sums[c] > bv) begin bi = c; bv = sums[c]; end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".index"}, 32'(out_index), 32'(bi));
    chk({tag, ".value"}, 32'(out_value), 32'(bv));
    if (check_scores) begin
      chk({tag, ".display"}, 32'(out_display), 32'(seg_ref(bi)));
      for (int c = 0; c < CAT; c++) begin
        score_sel = IDX_W'(c);
        #1;
        chk($sformatf("%s.score%0d", tag, c), 32'(score), 32'(sums[c]));
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".hs_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".hs_disp"}, 32'(out_display), 32'h00);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_bits = '0; out_ready = 1'b0; score_sel = '0;
    s_in_valid = 1'b0; s_in_bits = '0; s_out_ready = 1'b0; s_score_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_index", 32'(out_index), 32'd0);
    chk("rst.out_value", 32'(out_value), 32'd0);
    chk("rst.out_display", 32'(out_display), 32'h00);
    score_sel = 4'd7; #1;
    chk("rst.score7", 32'(score), 32'd0);

    // Category 7 all ones.
    clear_frame();
    set_cat_ones(7, 800);
    send_frame(0);
    check_result("cat7", 1'b1);
    chk("cat7.disp_const", 32'(out_display), 32'h07);
    score_sel = 4'd12; #1;
    chk("cat7.score_oob", 32'(score), 32'd0);

    // Backpressure with ones offered: nothing may be accepted.
    in_valid = 1'b1;
    in_bits  = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.index", k), 32'(out_index), 32'd7);
      chk($sformatf("bp%0d.value", k), 32'(out_value), 32'd800);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp.hs_ready", 32'(in_ready), 32'd1);
    chk("bp.hs_valid", 32'(out_valid), 32'd0);
    send_frame(0);
    check_result("bp_rerun", 1'b1);
    chk("bp_rerun.value_const", 32'(out_value), 32'd800);
    handshake("bp_rerun");

    // Tie between categories 2 and 5.
    clear_frame();
    set_cat_ones(2, 100);
    set_cat_ones(5, 100);
    send_frame(0);
    check_result("tie", 1'b1);
    chk("tie.index_const", 32'(out_index), 32'd2);
    chk("tie.value_const", 32'(out_value), 32'd100);
    handshake("tie");

    // Random bits with random input gaps.
    for (int f = 0; f < 50; f++) begin
      for (int i = 0; i < CAT*BEATS; i++) frame[i] = CH'({$urandom, $urandom});
      send_frame(30);
      check_result($sformatf("rnd%0d", f), 1'b0);
      handshake($sformatf("rnd%0d", f));
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 57; i++) frame[i] = '1;
    for (int i = 0; i < 57; i++) begin
      in_valid = 1'b1;
      in_bits  = frame[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    score_sel = 4'd0; #1;
    chk("midrst.score0", 32'(score), 32'd0);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    clear_frame();
    set_cat_ones(9, 640);
    send_frame(0);
    check_result("cat9", 1'b1);
    chk("cat9.index_const", 32'(out_index), 32'd9);
    chk("cat9.value_const", 32'(out_value), 32'd640);
    chk("cat9.disp_const", 32'(out_display), 32'h67);
    handshake("cat9");

    // Small build: 3 categories of 8 bits in 4-bit beats.
    begin
      logic [3:0] sv [6];
      sv = '{4'hF, 4'h1, 4'h3, 4'h3, 4'h0, 4'h0};
      for (int i = 0; i < 6; i++) begin
        s_in_valid = 1'b1;
        s_in_bits  = sv[i];
        @(posedge clk);
        #1;
      end
      s_in_valid = 1'b0;
    end
    chk("small.valid", 32'(s_out_valid), 32'd1);
    chk("small.index", 32'(s_out_index), 32'd0);
    chk("small.value", 32'(s_out_value), 32'd5);
    chk("small.display", 32'(s_out_display), 32'h3F);
    chk("small.in_ready", 32'(s_in_ready), 32'd0);
    s_score_sel = 2'd0; #1; chk("small.score0", 32'(s_score), 32'd5);
    s_score_sel = 2'd1; #1; chk("small.score1", 32'(s_score), 32'd4);
    s_score_sel = 2'd2; #1; chk("small.score2", 32'(s_score), 32'd0);
    s_score_sel = 2'd3; #1; chk("small.score3", 32'(s_score), 32'd0);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    chk("small.hs_valid", 32'(s_out_valid), 32'd0);
    chk("small.hs_ready", 32'(s_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
